// File: rtl/sound_scheduler.sv
// Note-sequence scheduler: steps a note-ROM address on every tick in ascending, descending or
// bouncing order, and lets a triggered beep burst interrupt the pattern, then resume it.
module sound_scheduler #(
    parameter int unsigned TICK_DIV   = 25_000_000,
    parameter int unsigned SCALE_LEN  = 8,
    parameter logic [7:0]  BEEP_ADDR  = 8'd5,
    parameter int unsigned BEEP_COUNT = 4,
    parameter int unsigned BEEP_ON    = 2,
    parameter int unsigned BEEP_OFF   = 2
) (
    input  logic       clk_100mHz,
    input  logic       rst,
    input  logic [2:0] mode,
    input  logic       beep_trigger,
    output logic [7:0] note_addr,
    output logic       note_en,
    output logic       beep_active,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_ASC      = 3'b001,
        S_ASC_DESC = 3'b010,
        S_DESC     = 3'b100,
        S_BEEP     = 3'b101,
        S_BEEP_GAP = 3'b110
    } state_t;

    localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IDX_W  = $clog2(BEEP_COUNT + 1);

    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  ON_LAST     = PH_W'(BEEP_ON - 1);
    localparam logic [PH_W-1:0]  OFF_LAST    = PH_W'(BEEP_OFF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BEEP_COUNT - 1);
    localparam logic [7:0]       ADDR_LAST   = 8'(SCALE_LEN - 1);
    localparam logic [7:0]       ADDR_PENULT = 8'(SCALE_LEN - 2);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             trig_q, trig_d;
    logic             pending_q, pending_d;
    logic             dir_up_q, dir_up_d;
    state_t           state_q, state_d;
    state_t           saved_state_q, saved_state_d;
    logic [7:0]       saved_addr_q, saved_addr_d;
    logic [7:0]       addr_q, addr_d;
    logic             en_q, en_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic   tick;
    logic   in_beep;
    logic   rise;
    state_t target;

    always_comb begin
        unique case (mode)
            3'b001:  target = S_ASC;
            3'b010:  target = S_DESC;
            3'b011:  target = S_ASC_DESC;
            default: target = S_IDLE;
        endcase
    end

    always_comb begin
        tick    = (tick_cnt_q == TICK_LAST);
        in_beep = (state_q == S_BEEP) || (state_q == S_BEEP_GAP);
        rise    = beep_trigger & ~trig_q;

        tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
        trig_d        = beep_trigger;
        pending_d     = pending_q;
        dir_up_d      = dir_up_q;
        state_d       = state_q;
        saved_state_d = saved_state_q;
        saved_addr_d  = saved_addr_q;
        addr_d        = addr_q;
        en_d          = en_q;
        phase_d       = phase_q;
        idx_d         = idx_q;

        if (tick) begin
            case (state_q)
                S_BEEP: begin
                    if (phase_q == ON_LAST) begin
                        state_d = S_BEEP_GAP;
                        en_d    = 1'b0;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                S_BEEP_GAP: begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = saved_state_q;
                            addr_d  = saved_addr_q;
                            en_d    = (saved_state_q != S_IDLE);
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_BEEP;
                            en_d    = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: begin
                    if (pending_q) begin
                        saved_state_d = state_q;
                        saved_addr_d  = addr_q;
                        pending_d     = 1'b0;
                        state_d       = S_BEEP;
                        addr_d        = BEEP_ADDR;
                        en_d          = 1'b1;
                        idx_d         = '0;
                        phase_d       = '0;
                    end else if (target != state_q) begin
                        state_d = target;
                        case (target)
                            S_ASC, S_ASC_DESC: begin
                                addr_d   = 8'd0;
                                dir_up_d = 1'b1;
                                en_d     = 1'b1;
                            end
                            S_DESC: begin
                                addr_d = ADDR_LAST;
                                en_d   = 1'b1;
                            end
                            default: en_d = 1'b0;
                        endcase
                    end else begin
                        // Bouncing mode turns at the endpoints without playing them twice
                        case (state_q)
                            S_ASC:  addr_d = (addr_q == ADDR_LAST) ? 8'd0 : addr_q + 8'd1;
                            S_DESC: addr_d = (addr_q == 8'd0) ? ADDR_LAST : addr_q - 8'd1;
                            S_ASC_DESC: begin
                                if (dir_up_q) begin
                                    if (addr_q == ADDR_LAST) begin
                                        addr_d   = ADDR_PENULT;
                                        dir_up_d = 1'b0;
                                    end else begin
                                        addr_d = addr_q + 8'd1;
                                    end
                                end else begin
                                    if (addr_q == 8'd0) begin
                                        addr_d   = 8'd1;
                                        dir_up_d = 1'b1;
                                    end else begin
                                        addr_d = addr_q - 8'd1;
                                    end
                                end
                            end
                            default: en_d = 1'b0;
                        endcase
                    end
                end
            endcase
        end

        if (rise && !in_beep) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100mHz or posedge rst) begin
        if (rst) begin
            tick_cnt_q    <= '0;
            trig_q        <= 1'b0;
            pending_q     <= 1'b0;
            dir_up_q      <= 1'b1;
            state_q       <= S_IDLE;
            saved_state_q <= S_IDLE;
            saved_addr_q  <= 8'd0;
            addr_q        <= 8'd0;
            en_q          <= 1'b0;
            phase_q       <= '0;
            idx_q         <= '0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            trig_q        <= trig_d;
            pending_q     <= pending_d;
            dir_up_q      <= dir_up_d;
            state_q       <= state_d;
            saved_state_q <= saved_state_d;
            saved_addr_q  <= saved_addr_d;
            addr_q        <= addr_d;
            en_q          <= en_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
        end
    end

    assign note_addr   = addr_q;
    assign note_en     = en_q;
    assign state       = state_q;
    assign beep_active = in_beep;

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler: directed pattern/beep/reset scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_sound_scheduler;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned SCALE_LEN  = 4;
    localparam logic [7:0]  BEEP_ADDR  = 8'd5;
    localparam int unsigned BEEP_COUNT = 2;
    localparam int unsigned BEEP_ON    = 1;
    localparam int unsigned BEEP_OFF   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = 3'b000;
    logic       beep_trigger = 1'b0;
    logic [7:0] note_addr;
    logic       note_en;
    logic       beep_active;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    sound_scheduler #(
        .TICK_DIV  (TICK_DIV),
        .SCALE_LEN (SCALE_LEN),
        .BEEP_ADDR (BEEP_ADDR),
        .BEEP_COUNT(BEEP_COUNT),
        .BEEP_ON   (BEEP_ON),
        .BEEP_OFF  (BEEP_OFF)
    ) dut (
        .clk_100mHz  (clk),
        .rst         (rst),
        .mode        (mode),
        .beep_trigger(beep_trigger),
        .note_addr   (note_addr),
        .note_en     (note_en),
        .beep_active (beep_active),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: a beep burst is expanded up front into the list of tick outputs it produces
    logic [2:0]  m_state, m_tgt, m_saved_state;
    logic [7:0]  m_addr, m_saved_addr;
    logic        m_en, m_up, m_pend, m_prev, m_rise, m_inbeep;
    int          m_cyc;
    logic [11:0] m_burst[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 3'b000; m_addr = 8'd0; m_en = 1'b0; m_up = 1'b1;
            m_pend = 1'b0; m_prev = 1'b0; m_cyc = 0;
            m_saved_state = 3'b000; m_saved_addr = 8'd0;
            m_burst.delete();
        end else begin
            m_rise   = beep_trigger && !m_prev;
            m_inbeep = (m_state == 3'b101) || (m_state == 3'b110);
            m_prev   = beep_trigger;
            m_cyc++;
            if (m_cyc % TICK_DIV == 0) begin
                if (m_burst.size() != 0) begin
                    {m_state, m_addr, m_en} = m_burst.pop_front();
                end else if (m_pend) begin
                    m_saved_state = m_state;
                    m_saved_addr  = m_addr;
                    for (int b = 0; b < BEEP_COUNT; b++) begin
                        for (int i = 0; i < BEEP_ON; i++)  m_burst.push_back({3'b101, BEEP_ADDR, 1'b1});
                        for (int i = 0; i < BEEP_OFF; i++) m_burst.push_back({3'b110, BEEP_ADDR, 1'b0});
                    end
                    m_burst.push_back({m_saved_state, m_saved_addr, m_saved_state != 3'b000});
                    {m_state, m_addr, m_en} = m_burst.pop_front();
                    m_pend = 1'b0;
                end else begin
                    case (mode)
                        3'b001:  m_tgt = 3'b001;
                        3'b010:  m_tgt = 3'b100;
                        3'b011:  m_tgt = 3'b010;
                        default: m_tgt = 3'b000;
                    endcase
                    if (m_tgt != m_state) begin
                        m_state = m_tgt;
                        m_en    = (m_tgt != 3'b000);
                        if (m_tgt == 3'b001 || m_tgt == 3'b010) begin
                            m_addr = 8'd0;
                            m_up   = 1'b1;
                        end else if (m_tgt == 3'b100) begin
                            m_addr = 8'(SCALE_LEN - 1);
                        end
                    end else if (m_state == 3'b001) begin
                        m_addr = 8'((int'(m_addr) + 1) % SCALE_LEN);
                    end else if (m_state == 3'b100) begin
                        m_addr = 8'((int'(m_addr) + SCALE_LEN - 1) % SCALE_LEN);
                    end else if (m_state == 3'b010) begin
                        if (m_up && int'(m_addr) == SCALE_LEN - 1) begin
                            m_up = 1'b0; m_addr = m_addr - 8'd1;
                        end else if (!m_up && m_addr == 8'd0) begin
                            m_up = 1'b1; m_addr = 8'd1;
                        end else begin
                            m_addr = m_up ? m_addr + 8'd1 : m_addr - 8'd1;
                        end
                    end
                end
            end
            if (m_rise && !m_inbeep) m_pend = 1'b1;
        end
    end

    int asc_exp  [5] = '{0, 1, 2, 3, 0};
    int desc_exp [5] = '{3, 2, 1, 0, 3};
    int bnc_exp  [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    task automatic reset_dut(input logic [2:0] m);
        rst = 1'b1;
        beep_trigger = 1'b0;
        mode = m;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick_wait;
        repeat (TICK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic pulse_then_tick;
        #3 beep_trigger = 1'b1;
        @(posedge clk);
        #4 beep_trigger = 1'b0;
        repeat (TICK_DIV - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        mode = 3'b001;
        beep_trigger = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({state, note_addr, note_en, beep_active} !== 13'd0) begin
            bad++;
            $display("FAIL reset_hold: got state=%b addr=%0d en=%b active=%b want all zero",
                     state, note_addr, note_en, beep_active);
        end
        beep_trigger = 1'b0;
    endtask

    task automatic test_ascending;
        logic [7:0] prev_addr;
        logic [2:0] prev_state;
        reset_dut(3'b001);
        prev_addr = 8'd0;
        prev_state = 3'b000;
        for (int k = 0; k < 5; k++) begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1;
            total++;
            if ({state, note_addr} !== {prev_state, prev_addr}) begin
                bad++;
                $display("FAIL asc_between[%0d]: got state=%b addr=%0d want state=%b addr=%0d",
                         k, state, note_addr, prev_state, prev_addr);
            end
            @(posedge clk);
            #1;
            total++;
            if ({state, note_addr, note_en} !== {3'b001, 8'(asc_exp[k]), 1'b1}) begin
                bad++;
                $display("FAIL asc[%0d]: got state=%b addr=%0d en=%b want state=001 addr=%0d en=1",
                         k, state, note_addr, note_en, asc_exp[k]);
            end
            prev_addr = 8'(asc_exp[k]);
            prev_state = 3'b001;
        end
    endtask

    task automatic test_descending;
        reset_dut(3'b010);
        for (int k = 0; k < 5; k++) begin
            tick_wait();
            total++;
            if ({state, note_addr, note_en} !== {3'b100, 8'(desc_exp[k]), 1'b1}) begin
                bad++;
                $display("FAIL desc[%0d]: got state=%b addr=%0d en=%b want state=100 addr=%0d en=1",
                         k, state, note_addr, note_en, desc_exp[k]);
            end
        end
    endtask

    task automatic test_bounce;
        reset_dut(3'b011);
        for (int k = 0; k < 8; k++) begin
            tick_wait();
            total++;
            if ({state, note_addr, note_en} !== {3'b010, 8'(bnc_exp[k]), 1'b1}) begin
                bad++;
                $display("FAIL bounce[%0d]: got state=%b addr=%0d en=%b want state=010 addr=%0d en=1",
                         k, state, note_addr, note_en, bnc_exp[k]);
            end
        end
    endtask

    task automatic test_beep;
        logic [2:0] st [6] = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b001, 3'b001};
        logic [7:0] ad [6] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd2, 8'd3};
        logic       en [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       act;
        reset_dut(3'b001);
        repeat (3) tick_wait();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) pulse_then_tick();
            else tick_wait();
            act = (st[k] == 3'b101) || (st[k] == 3'b110);
            total++;
            if ({state, note_addr, note_en, beep_active} !== {st[k], ad[k], en[k], act}) begin
                bad++;
                $display("FAIL beep[%0d]: got state=%b addr=%0d en=%b act=%b want state=%b addr=%0d en=%b act=%b",
                         k, state, note_addr, note_en, beep_active, st[k], ad[k], en[k], act);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] st [7] = '{3'b101, 3'b110, 3'b101, 3'b110, 3'b001, 3'b100, 3'b100};
        logic [7:0] ad [7] = '{8'd5, 8'd5, 8'd5, 8'd5, 8'd2, 8'd3, 8'd2};
        logic       en [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        reset_dut(3'b001);
        repeat (3) tick_wait();
        for (int k = 0; k < 7; k++) begin
            if (k == 2) mode = 3'b010;
            if (k == 0 || k == 2) pulse_then_tick();
            else tick_wait();
            total++;
            if ({state, note_addr, note_en} !== {st[k], ad[k], en[k]}) begin
                bad++;
                $display("FAIL ignore_retrigger[%0d]: got state=%b addr=%0d en=%b want state=%b addr=%0d en=%b",
                         k, state, note_addr, note_en, st[k], ad[k], en[k]);
            end
        end
    endtask

    task automatic test_reset_midburst;
        reset_dut(3'b001);
        tick_wait();
        pulse_then_tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({state, note_addr, note_en, beep_active} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset: got state=%b addr=%0d en=%b active=%b want all zero",
                     state, note_addr, note_en, beep_active);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (TICK_DIV - 1) @(posedge clk);
        #1;
        total++;
        if ({state, note_addr, note_en} !== 12'd0) begin
            bad++;
            $display("FAIL reset_early_tick: got state=%b addr=%0d en=%b want state=000 addr=0 en=0",
                     state, note_addr, note_en);
        end
        @(posedge clk);
        #1;
        total++;
        if ({state, note_addr, note_en} !== {3'b001, 8'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_first_tick: got state=%b addr=%0d en=%b want state=001 addr=0 en=1",
                     state, note_addr, note_en);
        end
    endtask

    task automatic test_random;
        logic exp_act;
        reset_dut(3'($urandom_range(0, 7)));
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 3) == 0) mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) pulse_then_tick();
            else tick_wait();
            exp_act = (m_state == 3'b101) || (m_state == 3'b110);
            total++;
            if ({state, note_addr, note_en, beep_active} !== {m_state, m_addr, m_en, exp_act}) begin
                bad++;
                $display("FAIL random[%0d]: got state=%b addr=%0d en=%b act=%b want state=%b addr=%0d en=%b act=%b",
                         k, state, note_addr, note_en, beep_active, m_state, m_addr, m_en, exp_act);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_bounce();
        test_beep();
        test_back_to_back();
        test_reset_midburst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
SOUND_SCHEDULER -- requirements
Module: sound_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000, clock cycles per note tick (0.25 s at 100 MHz); legal range >= 2.
REQ-002 Parameter SCALE_LEN, default 8, number of scale notes at note-ROM addresses 0..SCALE_LEN-1; legal range 2..255.
REQ-003 Parameter BEEP_ADDR, default 8'd5, note-ROM address played during a beep.
REQ-004 Parameters BEEP_COUNT, BEEP_ON and BEEP_OFF, defaults 4, 2 and 2: beeps per burst, ticks on per beep, ticks off per beep; each legal range >= 1.
REQ-005 clk_100mHz  in  1  sole clock, all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 mode  in  3  requested pattern: 001 ascending, 010 descending, 011 ascending/descending; any other value is idle.
REQ-008 beep_trigger  in  1  level input; a rising edge requests one beep burst.
REQ-009 note_addr  out  8  address to the note ROM, registered.
REQ-010 note_en  out  1  1 = tone generator plays note_addr; 0 = mute, registered.
REQ-011 beep_active  out  1  high while state is BEEP or BEEP_GAP.
REQ-012 state  out  3  current state: IDLE 000, ASC 001, ASC_DESC 010, DESC 100, BEEP 101, BEEP_GAP 110.

Function
REQ-013 Tick counter counts 0..TICK_DIV-1 and wraps; internal tick is high for the one cycle where the count equals TICK_DIV-1.
REQ-014 beep_trigger is registered once; a rising edge (current 1, previous 0) sets beep_pending in any state except BEEP or BEEP_GAP, where edges are ignored.
REQ-015 state, note_addr and note_en change only on tick cycles, except on reset.
REQ-016 Beep priority: on a tick with beep_pending=1 in IDLE/ASC/DESC/ASC_DESC, the block saves the current state and note_addr, clears beep_pending, and enters BEEP with note_addr=BEEP_ADDR, note_en=1, beep index=0 and phase count=0.
REQ-017 BEEP: after BEEP_ON ticks, go to BEEP_GAP with note_en=0; BEEP_GAP: after BEEP_OFF ticks, increment the beep index; if the index < BEEP_COUNT, return to BEEP; otherwise restore the saved state and note_addr, and set note_en=1 unless the restored state is IDLE.
REQ-018 Non-beep tick: the target state is decoded from mode; if it differs from the current state, load the start address (ASC and ASC_DESC: 0, direction up; DESC: SCALE_LEN-1; IDLE: hold address, note_en=0); if it is unchanged, advance the address.
REQ-019 ASC advance: addr+1, wrapping SCALE_LEN-1 -> 0.
REQ-020 DESC advance: addr-1, wrapping 0 -> SCALE_LEN-1.
REQ-021 ASC_DESC advance: step in the current direction; at SCALE_LEN-1 going up, output SCALE_LEN-2 and set direction down; at 0 going down, output 1 and set direction up; endpoints are never repeated.
REQ-022 The mode input is ignored during BEEP/BEEP_GAP; a mode change made during a burst takes effect on the first non-beep tick after the restore.
REQ-023 note_en=1 in ASC, DESC and ASC_DESC, and in BEEP; note_en=0 in IDLE and BEEP_GAP.
REQ-024 All address arithmetic is 8-bit and stays within 0..SCALE_LEN-1 outside beeps.

Reset
REQ-025 While rst=1: state=IDLE, note_addr=0, note_en=0, beep_active=0, tick counter=0, beep_pending=0, direction=up, saved state/address=IDLE/0, and the registered beep_trigger=0.
REQ-026 Reset mid-burst aborts the burst with no restore; after rst falls, the first tick occurs TICK_DIV cycles later.

Verification (TICK_DIV=4, SCALE_LEN=4, BEEP_COUNT=2, BEEP_ON=1, BEEP_OFF=1)
REQ-027 Reset then hold mode=001 -> at successive ticks note_addr=0,1,2,3,0 with note_en=1 and state=001; the ticks are 4 cycles apart.
REQ-028 mode=010 from IDLE -> note_addr=3,2,1,0,3 at successive ticks.
REQ-029 mode=011 -> note_addr=0,1,2,3,2,1,0,1 at successive ticks.
REQ-030 In ASC at addr 2, pulse beep_trigger for 1 cycle -> next tick BEEP addr 5 en=1; then BEEP_GAP en=0; BEEP; BEEP_GAP; then ASC restored at addr 2, then 3.
REQ-031 Re-pulse beep_trigger during BEEP_GAP -> ignored, and no second burst follows the restore; change mode to 010 mid-burst -> after the restore to ASC at addr 2, the next tick enters DESC at addr 3.
REQ-032 Assert rst asynchronously mid-burst -> all outputs are at their REQ-025 values within the same cycle, with no clock edge required.
